// File: rtl/bram_arbiter_if.sv
// Request/response port of the BRAM arbiter: one requester's handshake,
// address/data fields and the arbiter's grant and read/error responses.
interface bram_arbiter_if;
  logic        req;
  logic        we;
  logic [14:0] adr;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rd;
  logic        err;

  modport master (
    output req, we, adr, be, wd,
    input  gnt, rvalid, rd, err
  );

  modport slave (
    input  req, we, adr, be, wd,
    output gnt, rvalid, rd, err
  );
endinterface

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port BRAM (registered read data,
// one-cycle latency). Round-robin with a burst limit: while both ports
// request, the current owner keeps the BRAM for up to MAX_BURST grants.
// Read responses are routed by a tag captured at grant time.
//
// Arbiter state (last_b_q, burst_q):
//   state               | meaning
//   burst_q == 0        | no active streak; contested cycle goes to the port
//                       | that was not granted last (A after reset)
//   0 < burst_q < MAX   | streak in progress; contested cycle stays with owner
//   burst_q == MAX      | streak exhausted; contested cycle switches port
module bram_arbiter #(
  parameter int DEPTH     = 24576,
  parameter int MAX_BURST = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bram_arbiter_if.slave port_a,
  bram_arbiter_if.slave port_b,
  output logic [14:0]   adra_o,
  output logic [3:0]    bea_o,
  output logic          wea_o,
  output logic [31:0]   wda_o,
  input  logic [31:0]   rda_i
);

  localparam int            CW       = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BurstMax = CW'(MAX_BURST);
  localparam logic [31:0]   DepthU   = 32'(DEPTH);

  logic          last_b_q, last_b_d;
  logic [CW-1:0] burst_q, burst_d;

  logic gnt_a, gnt_b;
  logic a_oor, b_oor, sel_oor;

  logic rd_pend_q, rd_pend_d;
  logic rd_tag_b_q, rd_tag_b_d;
  logic rd_oor_q, rd_oor_d;
  logic err_a_q, err_a_d;
  logic err_b_q, err_b_d;

  logic [31:0] a_rd_q, b_rd_q;
  logic [31:0] rdata;
  logic        a_rvalid, b_rvalid;

  assign a_oor = (32'(port_a.adr) >= DepthU);
  assign b_oor = (32'(port_b.adr) >= DepthU);

  // Arbiter state register: last-granted pointer and burst counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_b_q <= 1'b1;
      burst_q  <= '0;
    end else begin
      last_b_q <= last_b_d;
      burst_q  <= burst_d;
    end
  end

  // Next arbiter state: count same-port streaks, restart on switch, clear on idle
  always_comb begin
    last_b_d = last_b_q;
    burst_d  = burst_q;
    if (gnt_a || gnt_b) begin
      if (gnt_b == last_b_q) begin
        if (burst_q != BurstMax) burst_d = burst_q + CW'(1);
      end else begin
        burst_d  = CW'(1);
        last_b_d = gnt_b;
      end
    end else begin
      burst_d = '0;
    end
  end

  // Grant decision and BRAM-side drive of the accepted access
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    adra_o  = '0;
    bea_o   = '0;
    wea_o   = 1'b0;
    wda_o   = '0;
    sel_oor = 1'b0;
    if (rst_ni) begin
      if (port_a.req && port_b.req) begin
        if ((burst_q != '0) && (burst_q < BurstMax)) begin
          gnt_a = ~last_b_q;
          gnt_b = last_b_q;
        end else begin
          gnt_a = last_b_q;
          gnt_b = ~last_b_q;
        end
      end else begin
        gnt_a = port_a.req;
        gnt_b = port_b.req;
      end
    end
    if (gnt_a) begin
      adra_o  = port_a.adr;
      bea_o   = port_a.be;
      wda_o   = port_a.wd;
      wea_o   = port_a.we & ~a_oor;
      sel_oor = a_oor;
    end else if (gnt_b) begin
      adra_o  = port_b.adr;
      bea_o   = port_b.be;
      wda_o   = port_b.wd;
      wea_o   = port_b.we & ~b_oor;
      sel_oor = b_oor;
    end
  end

  assign rd_pend_d  = (gnt_a & ~port_a.we) | (gnt_b & ~port_b.we);
  assign rd_tag_b_d = gnt_b;
  assign rd_oor_d   = sel_oor;
  assign err_a_d    = gnt_a & a_oor;
  assign err_b_d    = gnt_b & b_oor;

  // Response pipeline: the port tag travels with the read so data never follows the current grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q  <= 1'b0;
      rd_tag_b_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      err_a_q    <= 1'b0;
      err_b_q    <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_tag_b_q <= rd_tag_b_d;
      rd_oor_q   <= rd_oor_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
    end
  end

  // Out-of-range reads return zero instead of whatever the BRAM produced
  assign rdata    = rd_oor_q ? 32'h0 : rda_i;
  assign a_rvalid = rd_pend_q & ~rd_tag_b_q;
  assign b_rvalid = rd_pend_q & rd_tag_b_q;

  // Read-data hold registers: rd keeps the last delivered word between responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else begin
      if (a_rvalid) a_rd_q <= rdata;
      if (b_rvalid) b_rd_q <= rdata;
    end
  end

  assign port_a.gnt    = gnt_a;
  assign port_a.rvalid = a_rvalid;
  assign port_a.rd     = a_rvalid ? rdata : a_rd_q;
  assign port_a.err    = err_a_q;

  assign port_b.gnt    = gnt_b;
  assign port_b.rvalid = b_rvalid;
  assign port_b.rd     = b_rvalid ? rdata : b_rd_q;
  assign port_b.err    = err_b_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM model, transaction-level reference model,
// directed scenarios followed by randomized two-port traffic.
module tb_bram_arbiter;
  localparam int DEPTH     = 24576;
  localparam int MAX_BURST = 8;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [14:0] adr;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_arbiter_if pa ();
  bram_arbiter_if pb ();

  logic [14:0] adra;
  logic [3:0]  bea;
  logic        wea;
  logic [31:0] wda;
  logic [31:0] rda;

  bram_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .port_a (pa),
    .port_b (pb),
    .adra_o (adra),
    .bea_o  (bea),
    .wea_o  (wea),
    .wda_o  (wda),
    .rda_i  (rda)
  );

  // BRAM: write-first, byte enables, registered read
  logic [31:0] mem  [DEPTH];
  logic [31:0] gold [DEPTH];

  always @(posedge clk) begin : bram
    logic [31:0] w;
    if (int'(adra) < DEPTH) begin
      w = mem[adra];
      if (wea)
        for (int b = 0; b < 4; b++)
          if (bea[b]) w[8*b +: 8] = wda[8*b +: 8];
      mem[adra] = w;
      rda <= w;
    end else begin
      rda <= 32'hDEADBEEF;
    end
  end

  int total = 0;
  int bad = 0;

  // reference arbitration state: port ids 1=A, 2=B
  int last_port = 2;
  int run_len = 0;
  logic [31:0] ea_rd = 32'h0;
  logic [31:0] eb_rd = 32'h0;

  txn_t ca, cb;
  logic obs_ga, obs_gb, obs_wea;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic we, input int adr, input logic [3:0] be, input logic [31:0] wd);
    txn_t t;
    t.req = 1'b1;
    t.we  = we;
    t.adr = 15'(adr);
    t.be  = be;
    t.wd  = wd;
    return t;
  endfunction

  function automatic txn_t idle_txn();
    txn_t t;
    t = '0;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    int sel;
    int adr;
    sel = $urandom_range(0, 9);
    if (sel < 7)       adr = $urandom_range(0, 63);
    else if (sel == 7) adr = $urandom_range(DEPTH - 6, DEPTH - 1);
    else if (sel == 8) adr = $urandom_range(DEPTH, DEPTH + 5);
    else               adr = $urandom_range(DEPTH + 6, 32767);
    return mk(1'($urandom_range(0, 1)), adr, 4'($urandom), $urandom);
  endfunction

  task automatic apply();
    pa.req = ca.req; pa.we = ca.we; pa.adr = ca.adr; pa.be = ca.be; pa.wd = ca.wd;
    pb.req = cb.req; pb.we = cb.we; pb.adr = cb.adr; pb.be = cb.be; pb.wd = cb.wd;
  endtask

  // Expected winner from the round-robin / burst-limit rules
  function automatic int pick();
    if (ca.req && cb.req)
      return (run_len > 0 && run_len < MAX_BURST) ? last_port : 3 - last_port;
    if (ca.req) return 1;
    if (cb.req) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    last_port = 2;
    run_len = 0;
    ea_rd = 32'h0;
    eb_rd = 32'h0;
  endtask

  // One clock cycle: check grant/BRAM drive, advance model, check responses next cycle
  task automatic tick(output int g);
    txn_t t;
    bit inr, ra, rb, xa, xb;
    logic [31:0] v, data;
    apply();
    #1;
    g = pick();
    obs_ga = pa.gnt;
    obs_gb = pb.gnt;
    obs_wea = wea;
    chk("a_gnt", 32'(pa.gnt), 32'(g == 1));
    chk("b_gnt", 32'(pb.gnt), 32'(g == 2));
    t = (g == 1) ? ca : cb;
    inr = int'(t.adr) < DEPTH;
    if (g != 0) begin
      chk("adra", 32'(adra), 32'(t.adr));
      chk("bea",  32'(bea),  32'(t.be));
      chk("wea",  32'(wea),  32'(t.we && inr));
      chk("wda",  wda,       t.wd);
    end else begin
      chk("idle_bram", {adra, bea, wea, 12'h0}, 32'h0);
      chk("idle_wda", wda, 32'h0);
    end
    if (g == 0)              run_len = 0;
    else if (g == last_port) run_len++;
    else begin
      run_len = 1;
      last_port = g;
    end
    v = 32'h0;
    if (g != 0 && inr) begin
      v = gold[t.adr];
      if (t.we) begin
        for (int b = 0; b < 4; b++)
          if (t.be[b]) v[8*b +: 8] = t.wd[8*b +: 8];
        gold[t.adr] = v;
      end
    end
    data = inr ? v : 32'h0;
    ra = (g == 1) && !t.we;
    rb = (g == 2) && !t.we;
    xa = (g == 1) && !inr;
    xb = (g == 2) && !inr;
    @(posedge clk);
    @(negedge clk);
    if (ra) ea_rd = data;
    if (rb) eb_rd = data;
    chk("a_rvalid", 32'(pa.rvalid), 32'(ra));
    chk("b_rvalid", 32'(pb.rvalid), 32'(rb));
    chk("a_rd", pa.rd, ea_rd);
    chk("b_rd", pb.rd, eb_rd);
    chk("a_err", 32'(pa.err), 32'(xa));
    chk("b_err", 32'(pb.err), 32'(xb));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ca = mk(1'b0, 3, 4'hF, 32'h0);
    cb = mk(1'b1, 4, 4'hF, 32'h5555AAAA);
    apply();
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", {30'h0, pa.gnt, pb.gnt}, 32'h0);
      chk("rst_bram", {adra, bea, wea, 12'h0}, 32'h0);
      chk("rst_wda", wda, 32'h0);
      chk("rst_resp", {28'h0, pa.rvalid, pb.rvalid, pa.err, pb.err}, 32'h0);
      chk("rst_a_rd", pa.rd, 32'h0);
      chk("rst_b_rd", pb.rd, 32'h0);
    end
    model_reset();
    ca = idle_txn();
    cb = idle_txn();
    apply();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int g;
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      mem[i] = v;
      gold[i] = v;
    end
    ca = idle_txn();
    cb = idle_txn();
    apply();
    @(negedge clk);
    do_reset();

    // both ports reading continuously: A for 8 grants, B for 8, repeat
    ca = mk(1'b0, 5, 4'hF, 32'h0);
    cb = mk(1'b0, 6, 4'hF, 32'h0);
    for (int i = 0; i < 32; i++) begin
      tick(g);
      chk("rr_a_gnt", 32'(obs_ga), ((i % 16) < 8) ? 32'd1 : 32'd0);
      chk("rr_b_gnt", 32'(obs_gb), ((i % 16) < 8) ? 32'd0 : 32'd1);
    end
    ca = idle_txn(); cb = idle_txn(); tick(g);

    // byte-enable merge, read immediately after write
    ca = mk(1'b1, 16, 4'hF, 32'h11223344); tick(g);
    ca = mk(1'b1, 16, 4'b0101, 32'hAABBCCDD); tick(g);
    ca = mk(1'b0, 16, 4'hF, 32'h0); tick(g);
    chk("be_merge_rd", pa.rd, 32'h11BB33DD);
    chk("be_merge_rv", 32'(pa.rvalid), 32'd1);
    ca = idle_txn(); tick(g);

    // range boundary on port B
    cb = mk(1'b1, DEPTH, 4'hF, 32'hFFFFFFFF); tick(g);
    chk("oor_w_wea", 32'(obs_wea), 32'd0);
    chk("oor_w_err", 32'(pb.err), 32'd1);
    cb = idle_txn(); tick(g);
    chk("oor_err_once", 32'(pb.err), 32'd0);
    cb = mk(1'b0, DEPTH, 4'hF, 32'h0); tick(g);
    chk("oor_r_rv", 32'(pb.rvalid), 32'd1);
    chk("oor_r_rd", pb.rd, 32'h0);
    chk("oor_r_err", 32'(pb.err), 32'd1);
    cb = mk(1'b0, DEPTH - 1, 4'hF, 32'h0); tick(g);
    chk("edge_r_err", 32'(pb.err), 32'd0);
    chk("edge_r_rv", 32'(pb.rvalid), 32'd1);
    cb = mk(1'b1, DEPTH - 1, 4'hF, 32'h0BADF00D); tick(g);
    chk("edge_w_wea", 32'(obs_wea), 32'd1);
    cb = idle_txn(); tick(g);

    // back-to-back reads to different ports, routed by tag
    ca = mk(1'b0, 40, 4'hF, 32'h0);
    cb = mk(1'b0, 41, 4'hF, 32'h0);
    tick(g);
    chk("b2b_first_a", {30'h0, pa.rvalid, pb.rvalid}, 32'd2);
    ca = idle_txn();
    tick(g);
    chk("b2b_second_b", {30'h0, pa.rvalid, pb.rvalid}, 32'd1);
    cb = idle_txn(); tick(g);

    // single requester never forced off
    for (int i = 0; i < 20; i++) begin
      cb = mk(1'b0, i, 4'hF, 32'h0);
      tick(g);
      chk("b_only_gnt", 32'(obs_gb), 32'd1);
    end
    cb = idle_txn(); tick(g);

    // reset right after a read grant drops the pending response
    ca = mk(1'b0, 50, 4'hF, 32'h0);
    apply();
    #1;
    chk("rst_mid_gnt", 32'(pa.gnt), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    ca = idle_txn();
    apply();
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_resp", {28'h0, pa.rvalid, pb.rvalid, pa.err, pb.err}, 32'h0);
    end
    model_reset();
    rst_n = 1'b1;
    tick(g);
    tick(g);
    ca = mk(1'b0, 7, 4'hF, 32'h0);
    cb = mk(1'b0, 8, 4'hF, 32'h0);
    tick(g);
    chk("post_rst_a_wins", 32'(obs_ga), 32'd1);
    ca = idle_txn(); cb = idle_txn(); tick(g);

    // randomized traffic; requests held until granted
    for (int i = 0; i < 3000; i++) begin
      if (!ca.req && $urandom_range(0, 99) < 60) ca = rnd_txn();
      if (!cb.req && $urandom_range(0, 99) < 60) cb = rnd_txn();
      tick(g);
      if (g == 1) ca.req = 1'b0;
      if (g == 2) cb.req = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
